rr_dec_arbiter: RTL and testbench
=================================

RR_DEC_ARBITER -- requirements
Module: rr_dec_arbiter

Interface
- REQ-001: Parameter HOLD_MAX, default 4, SHALL set the maximum number of consecutive cycles one requester may hold a grant (legal range 1..15).
- REQ-002: clka  input  1  SHALL be the single clock; all state updates occur on its rising edge.
- REQ-003: rst  input  1  SHALL be the asynchronous, active-high reset.
- REQ-004: req  input  8  SHALL carry the request lines; req[i] high means requester i wants the shared decoder slot.
- REQ-005: E  output  1  SHALL drive the 3-to-8 decoder enable; high only while a grant is active.
- REQ-006: In  output  3  SHALL drive the decoder select, carrying the index of the granted requester.
- REQ-007: gnt  output  8  SHALL be the registered one-hot grant, equal to (1 << In) when E=1, else 8'h00.
- REQ-008: state  output  2  SHALL report the FSM state: 2'b00 IDLE, 2'b01 GRANT, 2'b10 GAP.
- REQ-009: hold_cnt  output  4  SHALL report the cycles elapsed in the current grant.

Function
- REQ-010: All outputs SHALL be registered; no combinational path from req to E, In or gnt.
- REQ-011: The FSM SHALL have exactly three states: IDLE, GRANT and GAP; the encoding 2'b11 SHALL return to IDLE on the next edge.
- REQ-012: Pointer ptr (3 bits, internal) SHALL hold the index of the last granted requester.
- REQ-013: Arbitration SHALL search indices ptr+1, ptr+2, ... ptr+8 modulo 8, in that order, and select the first with req high; ptr itself is checked last.
- REQ-014: In IDLE or GAP with any req bit high, the next edge SHALL enter GRANT with E=1, In=selected index, gnt one-hot, hold_cnt=0, ptr=selected index.
- REQ-015: In IDLE or GAP with req=8'h00, the next edge SHALL enter IDLE with E=0, gnt=8'h00; In and ptr SHALL keep their values.
- REQ-016: Latency from a request rising in IDLE to E=1 SHALL be exactly one clock edge.
- REQ-017: In GRANT, hold_cnt SHALL increment by 1 each edge while the grant continues.
- REQ-018: A grant SHALL be released at the next edge when req[In]=0 or hold_cnt=HOLD_MAX-1, whichever comes first.
- REQ-019: On release, the FSM SHALL enter GAP for exactly one cycle with E=0, gnt=8'h00 and hold_cnt=0, so that decoder outputs never overlap between requesters.
- REQ-020: A requester that drops and reasserts req during GAP SHALL be arbitrated normally; it is reached last because ptr equals its index.
- REQ-021: Changes to req[j] for j != In during GRANT SHALL have no effect until the next arbitration.
- REQ-022: With HOLD_MAX=1, every grant SHALL last exactly one cycle, followed by GAP.
- REQ-023: Sustained all-ones req SHALL produce grants in order 0,1,2,...,7,0 with a period of HOLD_MAX+1 cycles each.

Reset
- REQ-024: While rst=1, outputs SHALL be forced immediately (asynchronously) to: state=IDLE, E=0, In=3'b000, gnt=8'h00, hold_cnt=0; ptr SHALL be 3'b111, so that index 0 has first priority.
- REQ-025: A rst assertion during GRANT or GAP SHALL abort the grant at once; the first edge after rst deasserts SHALL arbitrate from IDLE.

Verification
- REQ-026: rst pulse, then req=8'h01 held for 10 cycles -> E rises one edge later, In=0, gnt=8'h01 for 4 cycles, GAP for 1 cycle, re-grant In=0; pattern repeats.
- REQ-027: req=8'hFF sustained -> In sequence 0,1,...,7,0, each held 4 cycles separated by a 1-cycle E=0 gap (period 5).
- REQ-028: req=8'h24 with ptr=2 and granted -> after release the next grant is In=5, then In=2.
- REQ-029: Grant at In=3, req[3] dropped after 2 cycles -> GAP at next edge, hold_cnt=0, E=0; with req=8'h00 the FSM returns to IDLE.
- REQ-030: rst asserted mid-GRANT (In=6, hold_cnt=2) -> E=0, gnt=8'h00, state=IDLE without waiting for a clock edge; after release with req=8'h40, grant In=6 after one edge.
- REQ-031: Every cycle, the checker SHALL hold: gnt == (E ? 1<<In : 0), at most one gnt bit set, and hold_cnt < HOLD_MAX.

Source files
------------

// File: rtl/rr_dec_arbiter.sv
// ---------------------------------------------------------------------------
// rr_dec_arbiter
//
// Round-robin arbiter that hands one shared 3-to-8 decoder slot to one of
// eight requesters at a time. A grant lasts until the owner drops its request
// or until it has held the slot for HOLD_MAX cycles. Each grant is followed
// by a single dead cycle (GAP) with the decoder disabled. This keeps the
// decoder outputs of two different requesters from ever overlapping.
//
// Parameters
//   HOLD_MAX  maximum consecutive cycles a requester may hold a grant (1..15)
//
// Ports
//   clka      in   1  single clock, all state changes on its rising edge
//   rst       in   1  asynchronous active-high reset
//   req       in   8  request lines, req[i] high = requester i wants the slot
//   E         out  1  decoder enable, high only while a grant is active
//   In        out  3  decoder select, index of the granted requester
//   gnt       out  8  registered one-hot grant, (1 << In) when E=1, else 0
//   state     out  2  FSM state: 00 IDLE, 01 GRANT, 10 GAP
//   hold_cnt  out  4  cycles elapsed in the current grant
// ---------------------------------------------------------------------------
module rr_dec_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clka,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       E,
    output logic [2:0] In,
    output logic [7:0] gnt,
    output logic [1:0] state,
    output logic [3:0] hold_cnt
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GRANT = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;

    // Last hold_cnt value a grant may show before it is forcibly released.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    // Index of the most recently granted requester; reset to 7 so that
    // requester 0 is the first one looked at after reset.
    logic [2:0] ptr;

    logic       pick_valid;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    logic [1:0] next_state;
    logic       next_e;
    logic [2:0] next_in;
    logic [7:0] next_gnt;
    logic [3:0] next_hold;
    logic [2:0] next_ptr;

    // Round-robin search starting just after ptr. The loop walks from the
    // farthest candidate (ptr itself) towards the nearest (ptr+1), so the
    // last hit written is the closest one in rotation order.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic. Every output is taken straight from
    // a flop, so nothing on req reaches E, In or gnt without a clock edge.
    always_comb begin
        next_state = state;
        next_e     = E;
        next_in    = In;
        next_gnt   = gnt;
        next_hold  = hold_cnt;
        next_ptr   = ptr;

        case (state)
            IDLE, GAP: begin
                if (pick_valid) begin
                    next_state = GRANT;
                    next_e     = 1'b1;
                    next_in    = pick_idx;
                    next_gnt   = 8'd1 << pick_idx;
                    next_hold  = 4'd0;
                    next_ptr   = pick_idx;
                end else begin
                    // Nobody asking: park in IDLE, keep In and ptr so the
                    // rotation resumes where it left off.
                    next_state = IDLE;
                    next_e     = 1'b0;
                    next_gnt   = 8'h00;
                    next_hold  = 4'd0;
                end
            end

            GRANT: begin
                if (!req[In] || (hold_cnt == HOLD_LAST)) begin
                    // Release into a one-cycle gap with the decoder off.
                    next_state = GAP;
                    next_e     = 1'b0;
                    next_gnt   = 8'h00;
                    next_hold  = 4'd0;
                end else begin
                    next_hold  = hold_cnt + 4'd1;
                end
            end

            default: begin
                // Unused encoding 2'b11 falls back to a clean IDLE.
                next_state = IDLE;
                next_e     = 1'b0;
                next_gnt   = 8'h00;
                next_hold  = 4'd0;
            end
        endcase
    end

    // State and output registers. Reset aborts any grant immediately and
    // leaves ptr at 7 so the first arbitration favours requester 0.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            E        <= 1'b0;
            In       <= 3'b000;
            gnt      <= 8'h00;
            hold_cnt <= 4'd0;
            ptr      <= 3'b111;
        end else begin
            state    <= next_state;
            E        <= next_e;
            In       <= next_in;
            gnt      <= next_gnt;
            hold_cnt <= next_hold;
            ptr      <= next_ptr;
        end
    end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_dec_arbiter
//
// Self-checking bench for rr_dec_arbiter. Two instances share one request
// bus: one uses HOLD_MAX=4 and the other HOLD_MAX=1. A reference model
// computes the expected outputs at every rising edge and pushes them into a
// per-instance queue. A separate monitor pops each entry shortly after the
// edge and compares it with the outputs. The monitor also checks the output
// invariants on every cycle.
// ---------------------------------------------------------------------------
module tb_rr_dec_arbiter;

    logic       clka = 1'b0;
    logic       rst;
    logic [7:0] req;

    logic       e_a,     e_b;
    logic [2:0] in_a,    in_b;
    logic [7:0] gnt_a,   gnt_b;
    logic [1:0] state_a, state_b;
    logic [3:0] hold_a,  hold_b;

    rr_dec_arbiter #(.HOLD_MAX(4)) dut_a (
        .clka(clka), .rst(rst), .req(req),
        .E(e_a), .In(in_a), .gnt(gnt_a), .state(state_a), .hold_cnt(hold_a)
    );

    rr_dec_arbiter #(.HOLD_MAX(1)) dut_b (
        .clka(clka), .rst(rst), .req(req),
        .E(e_b), .In(in_b), .gnt(gnt_b), .state(state_b), .hold_cnt(hold_b)
    );

    always #5 clka = ~clka;

    typedef struct packed {
        logic [1:0] state;
        logic       e;
        logic [2:0] in_idx;
        logic [7:0] gnt;
        logic [3:0] hold;
    } exp_t;

    exp_t exp_q_a[$];
    exp_t exp_q_b[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state per instance. It tracks who owns the slot, how
    // long the owner has held it, whether a gap cycle is pending, and the
    // last winner.
    int hold_max[2] = '{4, 1};
    bit active[2];
    bit gap[2];
    int owner[2];
    int held[2];
    int last[2];
    int shown[2];

    function automatic exp_t model_step(int u, logic [7:0] r, logic rs);
        exp_t x;
        if (rs) begin
            active[u] = 1'b0;
            gap[u]    = 1'b0;
            held[u]   = 0;
            last[u]   = 7;
            shown[u]  = 0;
        end else if (active[u]) begin
            if (!r[owner[u]] || held[u] == hold_max[u] - 1) begin
                active[u] = 1'b0;
                gap[u]    = 1'b1;
                held[u]   = 0;
            end else begin
                held[u] = held[u] + 1;
            end
        end else begin
            gap[u] = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (last[u] + k) % 8;
                if (r[idx]) begin
                    owner[u]  = idx;
                    last[u]   = idx;
                    shown[u]  = idx;
                    active[u] = 1'b1;
                    held[u]   = 0;
                    break;
                end
            end
        end
        x.state  = active[u] ? 2'd1 : (gap[u] ? 2'd2 : 2'd0);
        x.e      = active[u];
        x.in_idx = 3'(shown[u]);
        x.gnt    = active[u] ? 8'(1 << owner[u]) : 8'h00;
        x.hold   = 4'(held[u]);
        return x;
    endfunction

    task automatic check_output(string name, logic [7:0] act, logic [7:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // The model advances on every rising edge, using the same req and rst the
    // DUTs see.
    always @(posedge clka) begin
        exp_q_a.push_back(model_step(0, req, rst));
        exp_q_b.push_back(model_step(1, req, rst));
    end

    // The monitor samples 1 time unit after each edge and compares the
    // outputs with the queued expectations and with the invariants.
    always @(posedge clka) begin
        exp_t x;
        #1;
        if (exp_q_a.size() > 0) begin
            x = exp_q_a.pop_front();
            check_output("a.state", 8'(state_a), 8'(x.state));
            check_output("a.E",     8'(e_a),     8'(x.e));
            check_output("a.In",    8'(in_a),    8'(x.in_idx));
            check_output("a.gnt",   gnt_a,       x.gnt);
            check_output("a.hold",  8'(hold_a),  8'(x.hold));
        end
        if (exp_q_b.size() > 0) begin
            x = exp_q_b.pop_front();
            check_output("b.state", 8'(state_b), 8'(x.state));
            check_output("b.E",     8'(e_b),     8'(x.e));
            check_output("b.In",    8'(in_b),    8'(x.in_idx));
            check_output("b.gnt",   gnt_b,       x.gnt);
            check_output("b.hold",  8'(hold_b),  8'(x.hold));
        end
        check_output("a.gnt_vs_E",  gnt_a, e_a ? (8'd1 << in_a) : 8'd0);
        check_output("b.gnt_vs_E",  gnt_b, e_b ? (8'd1 << in_b) : 8'd0);
        check_output("a.onehot",    {7'd0, $onehot0(gnt_a)}, 8'd1);
        check_output("b.onehot",    {7'd0, $onehot0(gnt_b)}, 8'd1);
        check_output("a.hold_lt_max", {7'd0, (hold_a < 4'd4)}, 8'd1);
        check_output("b.hold_lt_max", {7'd0, (hold_b < 4'd1)}, 8'd1);
    end

    // Hold req at a fixed pattern for a number of cycles.
    task automatic apply_stimulus(logic [7:0] pattern, int cycles);
        @(negedge clka);
        req = pattern;
        repeat (cycles - 1) @(negedge clka);
    endtask

    // Random traffic. Some cycles get a new pattern of varying density, and
    // some cycles toggle a single bit so that owners drop out early.
    task automatic random_traffic(int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clka);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 8'h00;
                    1:       req = 8'd1 << $urandom_range(0, 7);
                    2:       req = 8'($urandom) & 8'($urandom);
                    default: req = 8'($urandom);
                endcase
            end else if ($urandom_range(0, 7) == 0) begin
                req = req ^ (8'd1 << $urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        repeat (2) @(negedge clka);
        rst = 1'b0;

        apply_stimulus(8'h01, 12);
        apply_stimulus(8'hFF, 45);
        apply_stimulus(8'h24, 15);
        random_traffic(300);

        // Drive an asynchronous reset into the middle of a grant at index 6.
        apply_stimulus(8'h00, 4);
        @(negedge clka);
        req = 8'h40;
        repeat (3) @(posedge clka);
        #3;
        check_output("pre_rst.state", 8'(state_a), 8'd1);
        check_output("pre_rst.In",    8'(in_a),    8'd6);
        check_output("pre_rst.hold",  8'(hold_a),  8'd2);
        rst = 1'b1;
        #1;
        check_output("async_rst.a.E",     8'(e_a),     8'd0);
        check_output("async_rst.a.gnt",   gnt_a,       8'h00);
        check_output("async_rst.a.state", 8'(state_a), 8'd0);
        check_output("async_rst.a.In",    8'(in_a),    8'd0);
        check_output("async_rst.a.hold",  8'(hold_a),  8'd0);
        check_output("async_rst.b.E",     8'(e_b),     8'd0);
        check_output("async_rst.b.gnt",   gnt_b,       8'h00);
        @(negedge clka);
        @(negedge clka);
        rst = 1'b0;
        @(posedge clka);
        #2;
        check_output("post_rst.E",  8'(e_a),  8'd1);
        check_output("post_rst.In", 8'(in_a), 8'd6);

        random_traffic(200);
        apply_stimulus(8'h00, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
